// File: rtl/dac_sdm.sv
// dac_sdm: 2nd-order MASH 1-1 delta-sigma modulator from the loop-filter word to the DCO DAC code.
// Optional LFSR dither on the stage-1 input is built when DAC_SDM_DITHER_EN is defined.
module dac_sdm #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 12,
  parameter int OUT_W  = 5
) (
  input  logic              clk_dlf,
  input  logic              rst,
  input  logic              en,
  input  logic              din_vld,
  input  logic [IN_W-1:0]   din,
  output logic [OUT_W-1:0]  dac_code,
  output logic              sat_flag
);

  localparam int IW = IN_W - FRAC_W;
  localparam int YW = ((IW > OUT_W) ? IW : OUT_W) + 3;
  localparam logic signed [YW-1:0] CODE_MAX = YW'((1 << OUT_W) - 1);

  logic [IN_W-1:0]         din_q;
  logic [FRAC_W-1:0]       acc1;
  logic [FRAC_W-1:0]       acc2;
  logic                    c2_d;
  logic [IW-1:0]           int_part;
  logic [FRAC_W-1:0]       frac_part;
  logic                    dith;
  logic [FRAC_W:0]         s1;
  logic [FRAC_W:0]         s2;
  logic                    c1;
  logic                    c2;
  logic signed [YW-1:0]    y;

  function automatic logic [OUT_W-1:0] clamp_code(input logic signed [YW-1:0] v);
    if (v[YW-1])
      return '0;
    else if (v > CODE_MAX)
      return '1;
    else
      return v[OUT_W-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [YW-1:0] v);
    return v[YW-1] || (v > CODE_MAX);
  endfunction

`ifdef DAC_SDM_DITHER_EN
  logic [14:0] lfsr;

  // x^15 + x^14 + 1; frozen while the modulator is disabled
  always_ff @(posedge clk_dlf) begin
    if (rst)
      lfsr <= 15'h4A5D;
    else if (en)
      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
  end

  assign dith = lfsr[0];
`else
  assign dith = 1'b0;
`endif

  assign int_part  = din_q[IN_W-1:FRAC_W];
  assign frac_part = din_q[FRAC_W-1:0];

  // Two cascaded first-order stages; stage-2 carry is differentiated via c2_d
  always_comb begin
    s1 = {1'b0, acc1} + {1'b0, frac_part} + {{FRAC_W{1'b0}}, dith};
    c1 = s1[FRAC_W];
    s2 = {1'b0, acc2} + {1'b0, s1[FRAC_W-1:0]};
    c2 = s2[FRAC_W];
    y  = $signed({{(YW-IW){1'b0}}, int_part})
       + $signed({{(YW-1){1'b0}}, c1})
       + $signed({{(YW-1){1'b0}}, c2})
       - $signed({{(YW-1){1'b0}}, c2_d});
  end

  // Register stage: captured input, modulator state and output code
  always_ff @(posedge clk_dlf) begin
    if (rst) begin
      din_q    <= '0;
      acc1     <= '0;
      acc2     <= '0;
      c2_d     <= 1'b0;
      dac_code <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (din_vld)
        din_q <= din;
      if (en) begin
        acc1     <= s1[FRAC_W-1:0];
        acc2     <= s2[FRAC_W-1:0];
        c2_d     <= c2;
        dac_code <= clamp_code(y);
        sat_flag <= out_of_range(y);
      end else begin
        // Disabled: pass the integer part straight through and restart from zero state
        acc1     <= '0;
        acc2     <= '0;
        c2_d     <= 1'b0;
        dac_code <= {{(OUT_W-IW){1'b0}}, int_part};
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dac_sdm.sv
// tb_dac_sdm: scoreboard bench for dac_sdm; a behavioural model pushes the expected
// {sat_flag, dac_code} per edge and a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dac_sdm;

  logic        clk_dlf = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        din_vld = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [4:0]  dac_code;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;

`ifdef DAC_SDM_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  // model state
  logic [15:0] m_dinq = '0;
  int          m_acc1 = 0;
  int          m_acc2 = 0;
  int          m_c2d  = 0;
  logic [14:0] m_lfsr = 15'h4A5D;

  logic [5:0]  exp_q[$];

  dac_sdm dut (
    .clk_dlf  (clk_dlf),
    .rst      (rst),
    .en       (en),
    .din_vld  (din_vld),
    .din      (din),
    .dac_code (dac_code),
    .sat_flag (sat_flag)
  );

  always #5 clk_dlf = ~clk_dlf;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk_dlf) begin
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({sat_flag, dac_code} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got code=%0d sat=%0b, expected code=%0d sat=%0b",
                 $time, dac_code, sat_flag, e[4:0], e[5]);
      end
    end
  end

  // drive one edge; the model predicts the registered outputs after that edge
  task automatic step(input logic r, input logic e, input logic v, input logic [15:0] d);
    int ii, ff, s1, s2, c1, c2, y, dth;
    logic [5:0] ex;
    rst = r; en = e; din_vld = v; din = d;
    if (r) begin
      ex = 6'd0;
      m_dinq = '0; m_acc1 = 0; m_acc2 = 0; m_c2d = 0; m_lfsr = 15'h4A5D;
    end else begin
      ii = int'(m_dinq[15:12]);
      ff = int'(m_dinq[11:0]);
      if (e) begin
        dth = DITHER ? int'(m_lfsr[0]) : 0;
        s1 = m_acc1 + ff + dth;
        c1 = s1 / 4096;
        s2 = m_acc2 + (s1 % 4096);
        c2 = s2 / 4096;
        y  = ii + c1 + c2 - m_c2d;
        if (y < 0)       ex = {1'b1, 5'd0};
        else if (y > 31) ex = {1'b1, 5'd31};
        else             ex = {1'b0, y[4:0]};
        m_acc1 = s1 % 4096; m_acc2 = s2 % 4096; m_c2d = c2;
        if (DITHER) m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
      end else begin
        ex = {1'b0, 1'b0, m_dinq[15:12]};
        m_acc1 = 0; m_acc2 = 0; m_c2d = 0;
      end
      if (v) m_dinq = d;
    end
    exp_q.push_back(ex);
    @(posedge clk_dlf);
    #1;
  endtask

  task automatic load(input logic [15:0] d);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 16'hFFFF);
      checks++;
      if (dac_code !== 5'd0 || sat_flag !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: code=%0d sat=%0b, required 0/0", i, dac_code, sat_flag);
      end
    end
  endtask

  task automatic test_integer_input;
    step(1'b0, 1'b1, 1'b1, 16'h3000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h3000);
      checks++;
      if (dac_code !== 5'd3) begin
        errors++;
        $display("FAIL integer_code edge %0d: code=%0d, required 3", i, dac_code);
      end
    end
  endtask

  task automatic test_mash_exact;
    int sum = 0, bad = 0, sats = 0;
    load(16'h3800);
    for (int i = 0; i < 4096; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h3800);
      sum += int'(dac_code);
      if (dac_code < 5'd2 || dac_code > 5'd5) bad++;
      if (sat_flag) sats++;
    end
    checks++;
    if (sum !== 14336) begin
      errors++;
      $display("FAIL mash_sum_3800: sum=%0d, required 14336", sum);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL mash_code_range: %0d codes outside 2..5, required 0", bad);
    end
    checks++;
    if (sats !== 0) begin
      errors++;
      $display("FAIL mash_no_sat: %0d sat pulses, required 0", sats);
    end
  endtask

  task automatic test_low_clamp;
    int wraps = 0, bad_sat = 0, sats = 0;
    load(16'h0001);
    for (int i = 0; i < 4096; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0001);
      if (dac_code == 5'd31) wraps++;
      if (sat_flag) begin
        sats++;
        if (dac_code != 5'd0) bad_sat++;
      end
    end
    checks++;
    if (wraps !== 0) begin
      errors++;
      $display("FAIL clamp_no_wrap: %0d codes of 31, required 0", wraps);
    end
    checks++;
    if (bad_sat !== 0) begin
      errors++;
      $display("FAIL clamp_sat_code: %0d sat pulses with nonzero code, required 0", bad_sat);
    end
    checks++;
    if (sats == 0) begin
      errors++;
      $display("FAIL clamp_sat_seen: sat pulses=%0d, required at least 1", sats);
    end
  endtask

  task automatic test_enable_drop;
    int sum = 0;
    load(16'h5400);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 16'h5400);
    step(1'b0, 1'b0, 1'b0, 16'h5400);
    checks++;
    if (dac_code !== 5'd5 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_code: code=%0d sat=%0b, required 5/0", dac_code, sat_flag);
    end
    checks++;
    if (dut.acc1 !== 12'd0 || dut.acc2 !== 12'd0 || dut.c2_d !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_state: acc1=%0d acc2=%0d c2_d=%0b, required 0/0/0", dut.acc1, dut.acc2, dut.c2_d);
    end
    for (int i = 0; i < 4096; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h5400);
      sum += int'(dac_code);
    end
    checks++;
    if (sum !== 21504) begin
      errors++;
      $display("FAIL reenable_sum_5400: sum=%0d, required 21504", sum);
    end
  endtask

  task automatic test_back_to_back;
    load(16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h2000);
    step(1'b0, 1'b1, 1'b1, 16'h7000);
    checks++;
    if (dac_code !== 5'd2) begin
      errors++;
      $display("FAIL enable_edge_old_din: code=%0d, required 2", dac_code);
    end
    step(1'b0, 1'b1, 1'b0, 16'h7000);
    checks++;
    if (dac_code !== 5'd7) begin
      errors++;
      $display("FAIL enable_edge_new_din: code=%0d, required 7", dac_code);
    end
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1), 16'($urandom()));
    end
  endtask

`ifdef DAC_SDM_DITHER_EN
  task automatic test_dither;
    int sum = 0, not_two = 0, diff;
    load(16'h2000);
    for (int i = 0; i < 4096; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h2000);
      sum += int'(dac_code);
      if (dac_code != 5'd2) not_two++;
    end
    diff = (sum > 8192) ? sum - 8192 : 8192 - sum;
    checks++;
    if (not_two == 0) begin
      errors++;
      $display("FAIL dither_active: all codes 2, required some variation");
    end
    checks++;
    if (diff > 1) begin
      errors++;
      $display("FAIL dither_sum: sum=%0d, required 8192 +/- 1", sum);
    end
    step(1'b1, 1'b1, 1'b0, 16'h2000);
    checks++;
    if (dut.lfsr !== 15'h4A5D) begin
      errors++;
      $display("FAIL dither_reseed: lfsr=%h, required 4a5d", dut.lfsr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_integer_input();
    test_mash_exact();
    test_low_clamp();
    test_enable_drop();
    test_back_to_back();
`ifdef DAC_SDM_DITHER_EN
    test_dither();
`endif
    @(negedge clk_dlf);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
